// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with blocking line fill from instruction memory
module icache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  ADDRESS,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    localparam int NUM_LINES = 1 << INDEX_BITS;
    localparam int TAG_BITS  = 28 - INDEX_BITS;

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_MEM_READ = 1'b1;

    // Line storage: only the valid bits carry reset state.
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
    logic [127:0]         r_data [NUM_LINES];

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    // {tag, index} of the access that missed; the fill is driven solely from this.
    logic [27:0] r_miss_addr;

    logic [1:0]            w_offset;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic [127:0]          w_line;
    logic [31:0]           w_word;
    logic                  w_fill;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_BITS-1:0]   w_fill_tag;
    logic                  w_unused_byte_offset;

    // Byte offset within a word is irrelevant for 32-bit aligned fetches.
    assign w_unused_byte_offset = ^ADDRESS[1:0];

    assign w_offset = ADDRESS[3:2];
    assign w_index  = ADDRESS[3+INDEX_BITS:4];
    assign w_tag    = ADDRESS[31:4+INDEX_BITS];

    assign w_line = r_data[w_index];
    assign w_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);

    assign w_fill_index = r_miss_addr[INDEX_BITS-1:0];
    assign w_fill_tag   = r_miss_addr[27:INDEX_BITS];

    // The line is written at the edge where memory reports the block ready.
    assign w_fill = (r_state == S_MEM_READ) && !MEM_BUSYWAIT;

    // Select the requested word out of the indexed line.
    always_comb begin
        w_word = 32'd0;
        unique case (w_offset)
            2'd0: w_word = w_line[31:0];
            2'd1: w_word = w_line[63:32];
            2'd2: w_word = w_line[95:64];
            2'd3: w_word = w_line[127:96];
            default: w_word = 32'd0;
        endcase
    end

    // Next-state logic: a miss in IDLE starts a fetch; a ready memory ends it.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:     if (!w_hit) w_state_next = S_MEM_READ;
            S_MEM_READ: if (!MEM_BUSYWAIT) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any fetch in flight so MEM_READ drops at once.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the missing block address when leaving IDLE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_miss_addr <= 28'd0;
        end else if ((r_state == S_IDLE) && !w_hit) begin
            r_miss_addr <= ADDRESS[31:4];
        end
    end

    // Valid bits: cleared by reset, set by a completed fill.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fill_index] <= 1'b1;
        end
    end

    // Tag and data arrays; a reset mid-fetch forces IDLE, so no partial fill lands.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= MEM_READDATA;
        end
    end

    // Outputs are held quiet during reset so the pipeline comes up cleanly.
    always_comb begin
        MEM_READ    = RESET && (r_state == S_MEM_READ);
        MEM_ADDRESS = MEM_READ ? r_miss_addr : 28'd0;
        BUSYWAIT    = RESET && ((r_state == S_MEM_READ) || !w_hit);
        INSTRUCTION = (RESET && w_hit) ? w_word : 32'd0;
    end

endmodule
